// File: rtl/irq_pend_ctrl.sv
// Interrupt pending capture, masking and single-outstanding req/ack dispatch.
// Sits in front of an external 8-bit priority encoder and consumes its result.

module irq_pend_lane #(
  parameter int EDGE_MODE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic clr,
  output logic pend
);

  logic prev;
  logic set;

  // prev resets low, so a source already high right after reset reads as an edge.
  assign set = (EDGE_MODE != 0) ? (irq_in & ~prev) : irq_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= irq_in;
      // Set dominates clear, so an event landing in the clear cycle is kept.
      pend <= (pend & ~clr) | set;
    end
  end

endmodule

module irq_pend_ctrl #(
  parameter int EDGE_MODE   = 1,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  output logic [7:0] pend_vec,
  input  logic [2:0] enc_idx,
  input  logic       enc_valid,
  output logic       irq_req,
  output logic [2:0] irq_id,
  input  logic       irq_ack,
  output logic [7:0] pending,
  output logic       timeout
);

  localparam int         NUM_SRC = 8;
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam bit         TO_EN   = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [7:0]         timer, timer_nxt;
  logic [2:0]         id_nxt;
  logic               to_nxt;
  logic [NUM_SRC-1:0] clr_vec;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    irq_pend_lane #(.EDGE_MODE(EDGE_MODE)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in[i]),
      .clr    (clr_vec[i]),
      .pend   (pending[i])
    );
  end

  assign pend_vec = pending & ~mask;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    id_nxt    = irq_id;
    to_nxt    = 1'b0;
    clr_vec   = '0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          id_nxt    = enc_idx;
          timer_nxt = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Ack beats a coincident timeout; the abandoned bit stays pending.
        if (irq_ack) begin
          state_nxt = CLEAR;
        end else if (TO_EN && timer == TO_LAST) begin
          to_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      CLEAR: begin
        clr_vec[irq_id] = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      irq_id  <= '0;
      irq_req <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      irq_id  <= id_nxt;
      irq_req <= (state_nxt == REQ);
      timeout <= to_nxt;
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench: edge-mode DUT with a 4-cycle ack timeout plus a level-mode DUT without timeout.

module tb_irq_pend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in, mask;
  logic [7:0] pend_vec, pending;
  logic [2:0] enc_idx, irq_id;
  logic       enc_valid, irq_req, irq_ack, timeout;

  logic [7:0] l_irq, l_pvec, l_pend;
  logic [2:0] l_eidx, l_id;
  logic       l_evld, l_req, l_ack, l_to;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // MSB-first priority encoder model: {valid, idx}
  function automatic logic [3:0] enc(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return {1'b1, 3'(i)};
    return 4'h0;
  endfunction

  assign {enc_valid, enc_idx} = enc(pend_vec);
  assign {l_evld, l_eidx}     = enc(l_pvec);

  irq_pend_ctrl #(.EDGE_MODE(1), .ACK_TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .pend_vec(pend_vec),
    .enc_idx(enc_idx), .enc_valid(enc_valid), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .pending(pending), .timeout(timeout)
  );

  irq_pend_ctrl #(.EDGE_MODE(0), .ACK_TIMEOUT(0)) u_lvl (
    .clk(clk), .rst(rst), .irq_in(l_irq), .mask(8'h00), .pend_vec(l_pvec),
    .enc_idx(l_eidx), .enc_valid(l_evld), .irq_req(l_req), .irq_id(l_id),
    .irq_ack(l_ack), .pending(l_pend), .timeout(l_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask = '0; irq_ack = 1'b0;
    l_irq = '0; l_ack = 1'b0;
    tick(2);
    chk("rst_pend", pending, 8'h00);
    chk("rst_req",  irq_req, 1'b0);
    chk("rst_id",   irq_id,  3'd0);
    chk("rst_to",   timeout, 1'b0);
    rst = 1'b0;
    tick();

    // single source 7
    irq_in = 8'h80; tick();
    chk("t1_pend", pending, 8'h80);
    chk("t1_req0", irq_req, 1'b0);
    irq_in = 8'h00; tick();
    chk("t1_req", irq_req, 1'b1);
    chk("t1_id",  irq_id,  3'd7);
    irq_ack = 1'b1; tick();
    chk("t1_ackreq", irq_req, 1'b0);
    chk("t1_ackpend", pending, 8'h80);
    irq_ack = 1'b0; tick();
    chk("t1_clr", pending, 8'h00);
    tick();
    chk("t1_idle", irq_req, 1'b0);

    // two sources, priority order 7 then 4
    irq_in = 8'h90; tick();
    chk("t2_pend", pending, 8'h90);
    irq_in = 8'h00; tick();
    chk("t2_id7", irq_id, 3'd7);
    chk("t2_req7", irq_req, 1'b1);
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; tick();
    chk("t2_pend10", pending, 8'h10);
    chk("t2_gap", irq_req, 1'b0);
    tick();
    chk("t2_req4", irq_req, 1'b1);
    chk("t2_id4",  irq_id,  3'd4);
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; tick();
    chk("t2_pend0", pending, 8'h00);
    tick();
    chk("t2_idle", irq_req, 1'b0);

    // masked capture, then unmask
    mask = 8'hFF; irq_in = 8'h20; tick();
    chk("t3_pend", pending, 8'h20);
    chk("t3_pvec", pend_vec, 8'h00);
    irq_in = 8'h00; tick(2);
    chk("t3_noreq", irq_req, 1'b0);
    mask = 8'h00; #1;
    chk("t3_pvec2", pend_vec, 8'h20);
    tick();
    chk("t3_req", irq_req, 1'b1);
    chk("t3_id",  irq_id,  3'd5);
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; tick();
    chk("t3_clr", pending, 8'h00);

    // timeout after 4 request cycles, then reissue; ack wins over timeout
    irq_in = 8'h08; tick();
    chk("t4_pend", pending, 8'h08);
    irq_in = 8'h00;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t4_reqhi", irq_req, 1'b1);
      chk("t4_to0",   timeout, 1'b0);
    end
    tick();
    chk("t4_reqlo", irq_req, 1'b0);
    chk("t4_to",    timeout, 1'b1);
    chk("t4_kept",  pending, 8'h08);
    tick();
    chk("t4_reiss", irq_req, 1'b1);
    chk("t4_id",    irq_id,  3'd3);
    chk("t4_topls", timeout, 1'b0);
    tick(3);
    irq_ack = 1'b1; tick();
    chk("t4_ackwin_req", irq_req, 1'b0);
    chk("t4_ackwin_to",  timeout, 1'b0);
    irq_ack = 1'b0; tick();
    chk("t4_clr", pending, 8'h00);

    // new edge on 7 during its clear cycle is retained
    irq_in = 8'h80; tick();
    irq_in = 8'h00; tick();
    chk("t5_req", irq_req, 1'b1);
    irq_ack = 1'b1; tick();
    chk("t5_clrst", irq_req, 1'b0);
    irq_ack = 1'b0; irq_in = 8'h80; tick();
    chk("t5_keep", pending, 8'h80);
    tick();
    chk("t5_rereq", irq_req, 1'b1);
    chk("t5_reid",  irq_id,  3'd7);

    // reset mid-request; source held high reads as an edge afterwards
    rst = 1'b1; tick();
    chk("t6_req",  irq_req, 1'b0);
    chk("t6_pend", pending, 8'h00);
    chk("t6_id",   irq_id,  3'd0);
    rst = 1'b0; tick();
    chk("t6_edge", pending, 8'h80);
    irq_in = 8'h00; tick();
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; tick(2);

    // level mode: held source re-requests; no timeout when disabled
    l_irq = 8'h04; tick();
    chk("l_pend", l_pend, 8'h04);
    tick();
    chk("l_req", l_req, 1'b1);
    chk("l_id",  l_id,  3'd2);
    tick(8);
    chk("l_hold", l_req, 1'b1);
    chk("l_noto", l_to,  1'b0);
    l_ack = 1'b1; tick();
    l_ack = 1'b0; tick();
    chk("l_reset", l_pend, 8'h04);
    tick();
    chk("l_again", l_req, 1'b1);
    l_irq = 8'h00; l_ack = 1'b1; tick();
    l_ack = 1'b0; tick();
    chk("l_clr", l_pend, 8'h00);
    tick();
    chk("l_idle", l_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pend_ctrl.md
Name: irq_pend_ctrl

Overview:
- Upstream stage of the 8-bit priority encoder, and the consumer of the encoder's result.
- Captures 8 interrupt sources into a pending register and applies a mask.
- Drives the masked pending vector to the encoder's `in`, then takes the encoder's `out`/`valid` back.
- Issues one request at a time to the CPU side with a req/ack handshake and clears the served pending bit.

Parameters:
- EDGE_MODE, 1: 1 = pending bit sets on a rising edge of irq_in; 0 = pending bit sets on level (every cycle irq_in is high).
- ACK_TIMEOUT, 0: cycles to wait for irq_ack before abandoning a request. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- irq_in  input  8  interrupt sources, synchronous to clk
- mask  input  8  1 = source masked (blocked from the encoder); pending still captured
- pend_vec  output  8  pending & ~mask, combinational; connects to encoder `in`
- enc_idx  input  3  encoder `out`
- enc_valid  input  1  encoder `valid`
- irq_req  output  1  request to CPU, registered
- irq_id  output  3  index of the active request, registered
- irq_ack  input  1  CPU acknowledge
- pending  output  8  raw pending register (status)
- timeout  output  1  one-cycle pulse when a request is abandoned

Behaviour:
- Reset (rst=1 at a clk edge):
  - pending=0, irq_prev=0, irq_req=0, irq_id=0, timeout=0, timer=0, state=IDLE.
  - Reset mid-request drops irq_req on the next cycle with no clear performed.
- Set event, per bit i:
  - EDGE_MODE=1: set_i = irq_in[i] & ~irq_prev[i].
  - EDGE_MODE=0: set_i = irq_in[i].
  - irq_prev <= irq_in every cycle.
  - A source already high at the first cycle after reset counts as an edge.
- pending[i] <= (pending[i] & ~clr_i) | set_i, so set wins over clear in the same cycle and the new event is retained.
- pend_vec is purely combinational from the pending register and mask. Mask changes affect encoder input in the same cycle.
- FSM, states IDLE, REQ, CLEAR:
  - IDLE:
    - If enc_valid=1: irq_id <= enc_idx, timer <= 0, go to REQ.
    - Otherwise stay in IDLE.
    - irq_req=0.
  - REQ:
    - irq_req=1 and irq_id held stable.
    - Mask and pending changes do not withdraw or alter the request.
    - If irq_ack=1: go to CLEAR.
    - Else if ACK_TIMEOUT≠0 and timer==ACK_TIMEOUT-1: timeout pulses 1 for one cycle, go to IDLE, and pending[irq_id] is kept.
    - Otherwise timer increments.
  - CLEAR:
    - clr_i=1 for i=irq_id for this one cycle only.
    - irq_req=0.
    - Go to IDLE unconditionally.
- irq_req is registered: it is 1 exactly while state==REQ.
- Latency:
  - irq_in rises before edge N.
  - pending bit is set at edge N.
  - state enters REQ at edge N+1, so irq_req is high after edge N+1.
  - Ack sampled at edge M: irq_req=0 after M, pending bit clears at M+1.
  - Earliest next request is at edge M+2.
- irq_ack in IDLE or CLEAR is ignored.
- Ack and the timeout condition in the same cycle: ack wins, timeout=0.
- All sources masked: enc_valid=0, so the FSM stays in IDLE while pending accumulates.
- Unmasking any pending bit triggers a request next cycle.
- EDGE_MODE=0 with irq_in still high re-sets the bit in the clear cycle, so the request repeats (level semantics).

Test Plan:
- Reset, then irq_in=8'b1000_0000 for one cycle, mask=0 → pending=8'h80 one edge later; irq_req=1, irq_id=7 one edge after that. Ack one cycle → irq_req=0, pending=8'h00 two edges after the ack.
- irq_in=8'b1001_0000 with an MSB-priority encoder model → serves irq_id=7 first; after ack, irq_id=4; after the second ack, pending=0 and irq_req stays 0.
- mask=8'hFF, irq_in pulse 8'b0010_0000 → pending=8'h20, pend_vec=0, irq_req stays 0. Set mask=0 → irq_req=1 with irq_id=5 one edge later.
- ACK_TIMEOUT=4, single source 3, no ack → irq_req high 4 cycles; timeout pulses once; pending[3] still 1; request re-issued with irq_id=3 after returning to IDLE.
- Second rising edge on source 7 in the same cycle the CLEAR state clears bit 7 → pending[7] remains 1 and a new request with irq_id=7 follows. Assert rst during REQ → next cycle irq_req=0, pending=0, irq_id=0.
